// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory access stage:
// size encodings, FSM states, alignment check and load lane extraction.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lane[0];
            SZ_WORD: ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Pick the addressed byte/half out of the memory word, then zero- or sign-extend.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge bus between the access unit (master) and data memory (slave).
interface mem_access_unit_if;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [3:0]  MemBe;
    logic        MemAck;
    logic [31:0] MemRdata;

    modport master (
        output MemReq, MemWe, MemAddr, MemWdata, MemBe,
        input  MemAck, MemRdata
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWdata, MemBe,
        output MemAck, MemRdata
    );
endinterface

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: byte enables and store-data replication from the CPU
// side, and lane extraction/extension of the returned memory word.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  rd_size_i,
    input  logic [1:0]  rd_lane_i,
    input  logic        rd_sext_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o
);

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SZ_WORD: be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

    assign rdata_o = lane_extract(rdata_i, rd_size_i, rd_lane_i, rd_sext_i);

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: turns ALU address / S2 data / control strobes into a
// req/ack memory transaction, stalls the PC while it is outstanding, returns load data.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        Clk_i,
    input  logic        Rst_n_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] WriteData_i,
    input  logic        MemRead_i,
    input  logic        MemToWrite_i,
    input  logic [1:0]  Size_i,
    input  logic        SignExt_i,
    output logic [31:0] ReadData_o,
    output logic        Done_o,
    output logic        Stall_o,
    output logic        Misaligned_o,
    output logic        Fault_o,
    mem_access_unit_if.master mem_if
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [31:0] read_data_q;
    logic        done_q, misaligned_q, fault_q;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [1:0]  size_q, lane_q;
    logic        sext_q;

    logic        start, aligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] rd_ext;

    assign start   = MemRead_i | MemToWrite_i;
    assign aligned = is_aligned(Size_i, Address_i[1:0]);
    assign cnt_d   = cnt_q + 8'd1;

    mem_lane_unit u_lane (
        .size_i    (Size_i),
        .lane_i    (Address_i[1:0]),
        .wdata_i   (WriteData_i),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .rd_size_i (size_q),
        .rd_lane_i (lane_q),
        .rd_sext_i (sext_q),
        .rdata_i   (mem_if.MemRdata),
        .rdata_o   (rd_ext)
    );

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            read_data_q  <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            size_q       <= '0;
            lane_q       <= '0;
            sext_q       <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && aligned) begin
                        // A store wins when both strobes are high.
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        we_q    <= MemToWrite_i;
                        addr_q  <= {Address_i[31:2], 2'b00};
                        wdata_q <= lane_wdata;
                        be_q    <= lane_be;
                        size_q  <= Size_i;
                        lane_q  <= Address_i[1:0];
                        sext_q  <= SignExt_i;
                        cnt_q   <= '0;
                    end else if (start) begin
                        misaligned_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_if.MemAck) begin
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= RESP;
                        if (!we_q) read_data_q <= rd_ext;
                    end else if (cnt_d == TIMEOUT_LIMIT) begin
                        req_q   <= 1'b0;
                        fault_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Stall_o         = (state_q != IDLE) || (start && aligned);
    assign ReadData_o      = read_data_q;
    assign Done_o          = done_q;
    assign Misaligned_o    = misaligned_q;
    assign Fault_o         = fault_q;
    assign mem_if.MemReq   = req_q;
    assign mem_if.MemWe    = we_q;
    assign mem_if.MemAddr  = addr_q;
    assign mem_if.MemWdata = wdata_q;
    assign mem_if.MemBe    = be_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage directly downstream of the ALU and the MemToReg write-back mux.
- Takes the ALU result as an address, the register-file second operand (S2) as store data, and the control-unit MemRead/MemToWrite strobes.
- Runs a req/ack transaction with an external data memory and returns load data for the write-back mux.
- Asserts Stall so the PC holds while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles to wait for MemAck before aborting; valid range 1..255.

Ports:
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- Address  in  32  byte address from the ALU result
- WriteData  in  32  store data from register-file port S2
- MemRead  in  1  load request from the control unit
- MemToWrite  in  1  store request from the control unit
- Size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- SignExt  in  1  loads only: 1 sign-extends, 0 zero-extends
- ReadData  out  32  extended load result, held until the next load completes
- Done  out  1  one-cycle pulse when an access completes
- Stall  out  1  freezes the PC and the datapath while high
- Misaligned  out  1  one-cycle pulse when an access is rejected
- Fault  out  1  one-cycle pulse when an access times out
- MemReq  out  1  memory request
- MemWe  out  1  memory write enable
- MemAddr  out  32  word address, equal to {Address[31:2],2'b00}
- MemWdata  out  32  lane-replicated store data
- MemBe  out  4  byte enables
- MemAck  in  1  memory acknowledge
- MemRdata  in  32  memory read word, valid while MemAck is high

Behaviour:
- Reset values: state IDLE; ReadData=0, Done=0, Misaligned=0, Fault=0, MemReq=0, MemWe=0, MemAddr=0, MemWdata=0, MemBe=0.
- Stall is combinational: (state!=IDLE) | (state==IDLE & start & aligned).
- start = MemRead | MemToWrite. If both are high, the access is a store and the read is ignored.
- Alignment rules:
  - half accesses require Address[0]=0;
  - word accesses require Address[1:0]=0;
  - Size=11 is always rejected.
- A rejected access in IDLE produces a Misaligned pulse on the next cycle, raises no Stall, and never asserts MemReq.
- FSM states: IDLE, REQ, RESP.
- IDLE -> REQ on start with an aligned access. The memory-side outputs and the timeout counter (cleared to 0) are registered on this edge. MemReq is high from the next cycle.
- REQ:
  - MemReq is held high, and all memory-side outputs are held stable until MemAck is sampled high.
  - On ack: a load captures MemRdata, then lane-extracts and extends it into ReadData. The FSM then goes to RESP.
  - If the counter reaches TIMEOUT_CYCLES with no ack: MemReq drops, Fault pulses, ReadData is unchanged, and the FSM goes to RESP.
- RESP: MemReq=0; Done pulses (suppressed on timeout); Stall stays high for this cycle; the FSM returns to IDLE.
- Latency: with MemAck high in the first REQ cycle, the access takes 3 cycles (IDLE-start, REQ, RESP). Stall is high for 3 cycles, and the PC advances on the edge after RESP.
- Byte lanes (little-endian, lane = Address[1:0]):
  - byte: MemBe = 1<<lane; MemWdata = {4{WriteData[7:0]}}.
  - half: MemBe = 0011 or 1100; MemWdata = {2{WriteData[15:0]}}.
  - word: MemBe = 1111; MemWdata = WriteData.
  - Loads drive MemBe the same way; MemWe = 0.
- Load extraction selects the addressed lane from MemRdata, then applies the SignExt rule.
- Inputs are sampled only on the IDLE->REQ edge. Changes while Stall is high have no effect.
- A MemAck seen outside REQ is ignored.
- Asynchronous reset mid-transaction forces IDLE immediately and drops MemReq; no Done or Fault pulse is produced.
- Counter width is 8 bits. It never wraps, because the FSM leaves REQ at TIMEOUT_CYCLES.

Decomposition:
- Shared package mem_pkg:
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state typedef: IDLE, REQ, RESP.
  - Lane-extract/extend function.
- One sub-module, mem_lane_unit: combinational byte-enable and write-data replication, plus read extraction and extension. It is instantiated once.

Test Plan:
- Word store: Address=0x0000_0010, WriteData=0xDEADBEEF, MemToWrite=1, Size=10, ack in the first REQ cycle. Expect MemAddr=0x10, MemBe=1111, MemWe=1, MemWdata=0xDEADBEEF, Stall high for 3 cycles, one Done pulse.
- Signed byte load: Address=0x13, MemRdata=0x80_00_00_00, Size=00, SignExt=1. Expect MemBe=1000, ReadData=0xFFFF_FF80. Repeat with SignExt=0: expect 0x0000_0080.
- Half load: Address=0x22, MemRdata=0x1234_5678, SignExt=0. Expect MemBe=1100, ReadData=0x0000_1234.
- Misaligned word: Address=0x06, Size=10. Expect no MemReq, Stall=0, one Misaligned pulse, ReadData unchanged.
- Timeout: TIMEOUT_CYCLES=4 with MemAck held low. Expect MemReq high for 4 cycles, one Fault pulse, no Done, ReadData unchanged.
- Reset mid-access: Rst_n pulled low in the 2nd REQ cycle. Expect MemReq=0 and Stall=0 immediately, all outputs at reset values, and a later ack with no effect.
